priv_trap_ctrl: RTL and testbench

Parametrised machine-mode trap controller for the v1.12 privilege block. It replaces the fixed interrupt/exception handler and PC-redirect logic with one sequential unit. The unit handles a configurable number of interrupt and exception sources, latches pending interrupts, and arbitrates by fixed priority. It waits for the pipeline to drain, then issues a single-cycle CSR inject and PC redirect, with optional vectored dispatch. It sits between the CSR file and pipeline control inside the privilege block.

---
 rtl/priv_trap_pkg.sv | 23 ++
 rtl/priv_trap_if.sv | 49 ++++
 rtl/priv_prio_enc.sv | 26 ++
 rtl/priv_trap_ctrl.sv | 131 +++++++++++++
 tb/tb_priv_trap_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/priv_trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
// Imported by the encoder and the controller.
package priv_trap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CLEAR,
    TRAP,
    RET
  } trap_state_t;

  localparam int CAUSE_W = 5;
  localparam int DEF_XLEN = 32;
  localparam int MCAUSE_INT_BIT = DEF_XLEN - 1;

  localparam logic [1:0] DIRECT = 2'b00;
  localparam logic [1:0] VECTORED = 2'b01;

  function automatic int mcause_int_bit(int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/priv_trap_if.sv
// Trap controller bus: interrupt/exception sources, CSR values and
// redirect outputs. master = controller, slave = CSR file / pipeline.
interface priv_trap_if #(
  parameter int NUM_INT = 16,
  parameter int NUM_EXC = 16,
  parameter int XLEN = 32
);

  logic [NUM_INT-1:0] int_req;
  logic [NUM_INT-1:0] int_clear;
  logic [NUM_INT-1:0] mie;
  logic mstatus_mie;
  logic [NUM_EXC-1:0] exc_req;
  logic [XLEN-1:0] exc_tval;
  logic [XLEN-1:0] epc;
  logic pipe_clear;
  logic mret;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc_in;

  logic [NUM_INT-1:0] mip;
  logic inject;
  logic ret_restore;
  logic [XLEN-1:0] next_mcause;
  logic [XLEN-1:0] next_mepc;
  logic [XLEN-1:0] next_mtval;
  logic insert_pc;
  logic [XLEN-1:0] priv_pc;
  logic busy;

  modport master (
    input int_req, int_clear, mie, mstatus_mie,
    input exc_req, exc_tval, epc, pipe_clear,
    input mret, mtvec, mepc_in,
    output mip, inject, ret_restore,
    output next_mcause, next_mepc, next_mtval,
    output insert_pc, priv_pc, busy
  );

  modport slave (
    output int_req, int_clear, mie, mstatus_mie,
    output exc_req, exc_tval, epc, pipe_clear,
    output mret, mtvec, mepc_in,
    input mip, inject, ret_restore,
    input next_mcause, next_mepc, next_mtval,
    input insert_pc, priv_pc, busy
  );

endinterface

// File: rtl/priv_prio_enc.sv
// Fixed-priority encoder, LSB-first or MSB-first.
// valid is the OR of all requests; idx is 0 when nothing is requested.
module priv_prio_enc
  import priv_trap_pkg::*;
#(
  parameter int W = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [W-1:0] req,
  output logic valid,
  output logic [CAUSE_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (MSB_FIRST) begin
        if (req[i]) idx = CAUSE_W'(i);
      end else begin
        if (req[W-1-i]) idx = CAUSE_W'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/priv_trap_ctrl.sv
// Machine-mode trap controller: pending latch, arbitration,
// drain wait and single-cycle CSR inject / PC redirect.
module priv_trap_ctrl #(
  parameter int NUM_INT = 16,
  parameter int NUM_EXC = 16,
  parameter int XLEN = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input logic CLK,
  input logic nRST,
  priv_trap_if.master bus
);

  import priv_trap_pkg::*;

  localparam int INT_BIT = mcause_int_bit(XLEN);

  trap_state_t state;
  logic [NUM_INT-1:0] mip_q;
  logic [NUM_INT-1:0] elig;
  logic lat_int;
  logic inject_q, insert_q, restore_q, busy_q;
  logic [XLEN-1:0] mcause_q, mepc_q, mtval_q, pc_q;

  logic exc_v, int_v;
  logic [CAUSE_W-1:0] exc_idx, int_idx, idx;
  logic is_int, vec;
  logic [XLEN-1:0] base, cause_w, tval_w, tgt_w;

  assign elig = mip_q & bus.mie & {NUM_INT{bus.mstatus_mie}};

  priv_prio_enc #(.W(NUM_EXC), .MSB_FIRST(1'b0)) u_exc_enc (
    .req(bus.exc_req),
    .valid(exc_v),
    .idx(exc_idx)
  );

  priv_prio_enc #(.W(NUM_INT), .MSB_FIRST(1'b1)) u_int_enc (
    .req(elig),
    .valid(int_v),
    .idx(int_idx)
  );

  // Any exception outranks any interrupt.
  always_comb begin
    is_int = !exc_v;
    idx = exc_v ? exc_idx : int_idx;
    cause_w = '0;
    cause_w[CAUSE_W-1:0] = idx;
    cause_w[INT_BIT] = is_int;
    tval_w = exc_v ? bus.exc_tval : '0;
    base = {bus.mtvec[XLEN-1:2], DIRECT};
    vec = VECTORED_EN && is_int
      && (bus.mtvec[1:0] == VECTORED);
    tgt_w = vec ? base + (XLEN'(idx) << 2) : base;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      mip_q <= '0;
      lat_int <= 1'b0;
      inject_q <= 1'b0;
      insert_q <= 1'b0;
      restore_q <= 1'b0;
      busy_q <= 1'b0;
      mcause_q <= '0;
      mepc_q <= '0;
      mtval_q <= '0;
      pc_q <= '0;
    end else begin
      mip_q <= (mip_q | bus.int_req) & ~bus.int_clear;
      inject_q <= 1'b0;
      insert_q <= 1'b0;
      restore_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exc_v || int_v) begin
            state <= WAIT_CLEAR;
            busy_q <= 1'b1;
            lat_int <= is_int;
            mcause_q <= cause_w;
            mepc_q <= bus.epc;
            mtval_q <= tval_w;
            pc_q <= tgt_w;
          end else if (bus.mret) begin
            state <= RET;
            busy_q <= 1'b1;
            insert_q <= 1'b1;
            restore_q <= 1'b1;
            pc_q <= bus.mepc_in;
          end
        end
        WAIT_CLEAR: begin
          // A late exception replaces a latched interrupt.
          if (exc_v && lat_int) begin
            lat_int <= 1'b0;
            mcause_q <= cause_w;
            mepc_q <= bus.epc;
            mtval_q <= tval_w;
            pc_q <= tgt_w;
          end
          if (bus.pipe_clear) begin
            state <= TRAP;
            inject_q <= 1'b1;
            insert_q <= 1'b1;
          end
        end
        TRAP, RET: begin
          state <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mip = mip_q;
  assign bus.inject = inject_q;
  assign bus.ret_restore = restore_q;
  assign bus.insert_pc = insert_q;
  assign bus.busy = busy_q;
  assign bus.next_mcause = mcause_q;
  assign bus.next_mepc = mepc_q;
  assign bus.next_mtval = mtval_q;
  assign bus.priv_pc = pc_q;

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Scoreboard bench for priv_trap_ctrl: expected redirects are queued
// at stimulus time and popped when insert_pc appears.
module tb_priv_trap_ctrl;

  logic clk;
  logic rst_n;
  int cyc;
  int n_chk;
  int n_fail;

  typedef struct {
    bit ret;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] pc;
    int due;
  } exp_t;

  exp_t sb[$];

  priv_trap_if #(.NUM_INT(16), .NUM_EXC(16), .XLEN(32)) bus ();

  priv_trap_ctrl #(
    .NUM_INT(16),
    .NUM_EXC(16),
    .XLEN(32),
    .VECTORED_EN(1'b1)
  ) dut (
    .CLK(clk),
    .nRST(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(bit ret, logic [31:0] cause, logic [31:0] epc,
                      logic [31:0] tval, logic [31:0] pc, int due);
    exp_t e;
    e.ret = ret;
    e.cause = cause;
    e.epc = epc;
    e.tval = tval;
    e.pc = pc;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic clear_mip();
    bus.int_clear = '1;
    tick();
    bus.int_clear = '0;
  endtask

  // Redirect monitor
  always @(negedge clk) begin
    if (bus.insert_pc) begin
      if (sb.size() == 0) begin
        chk("spurious_redirect", 32'(bus.insert_pc), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("redir_cycle", cyc, e.due);
        chk("inject", 32'(bus.inject), 32'(!e.ret));
        chk("ret_restore", 32'(bus.ret_restore), 32'(e.ret));
        chk("priv_pc", bus.priv_pc, e.pc);
        if (!e.ret) begin
          chk("mcause", bus.next_mcause, e.cause);
          chk("mepc", bus.next_mepc, e.epc);
          chk("mtval", bus.next_mtval, e.tval);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.int_req = '0;
    bus.int_clear = '0;
    bus.mie = 16'hFFFF;
    bus.mstatus_mie = 1'b1;
    bus.exc_req = '0;
    bus.exc_tval = '0;
    bus.epc = '0;
    bus.pipe_clear = 1'b1;
    bus.mret = 1'b0;
    bus.mtvec = 32'h8000_0001;
    bus.mepc_in = '0;
    tick();
    tick();
    chk("rst_mip", 32'(bus.mip), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_insert", 32'(bus.insert_pc), 32'd0);
    chk("rst_mcause", bus.next_mcause, 32'd0);
    chk("rst_pc", bus.priv_pc, 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset while waiting for the pipeline to drain
    bus.pipe_clear = 1'b0;
    bus.exc_req = 16'h0001;
    bus.exc_tval = 32'h0000_00AA;
    bus.epc = 32'h0000_0040;
    tick();
    bus.exc_req = '0;
    chk("wc_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_inject", 32'(bus.inject), 32'd0);
    chk("mid_rst_mepc", bus.next_mepc, 32'd0);
    chk("mid_rst_mtval", bus.next_mtval, 32'd0);
    chk("mid_rst_pc", bus.priv_pc, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.pipe_clear = 1'b1;
    repeat (4) tick();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    // Vectored interrupt, highest eligible index wins
    bus.epc = 32'h0000_0100;
    bus.int_req = 16'h0808;
    push(1'b0, 32'h8000_000B, 32'h100, 32'h0, 32'h8000_002C, cyc + 3);
    tick();
    bus.int_req = '0;
    chk("mip_pend", 32'(bus.mip), 32'h0808);
    drain("vec_int");
    clear_mip();

    // Exception outranks an eligible interrupt
    bus.int_req = 16'h0080;
    tick();
    bus.int_req = '0;
    bus.exc_req = 16'h0024;
    bus.exc_tval = 32'hDEAD_BEEF;
    bus.epc = 32'h0000_0200;
    push(1'b0, 32'h0000_0002, 32'h200, 32'hDEAD_BEEF, 32'h8000_0000,
         cyc + 2);
    tick();
    bus.exc_req = '0;
    drain("exc_over_int");
    clear_mip();

    // Late exception replaces a latched interrupt in WAIT_CLEAR
    bus.pipe_clear = 1'b0;
    bus.int_req = 16'h0020;
    bus.epc = 32'h0000_0300;
    tick();
    bus.int_req = '0;
    tick();
    repeat (4) tick();
    chk("wc_hold_busy", 32'(bus.busy), 32'd1);
    chk("wc_int_cause", bus.next_mcause, 32'h8000_0005);
    chk("wc_int_pc", bus.priv_pc, 32'h8000_0014);
    bus.exc_req = 16'h0002;
    bus.exc_tval = 32'h0000_0055;
    bus.epc = 32'h0000_0304;
    tick();
    bus.exc_req = '0;
    chk("wc_exc_cause", bus.next_mcause, 32'h0000_0001);
    chk("wc_exc_tval", bus.next_mtval, 32'h0000_0055);
    push(1'b0, 32'h0000_0001, 32'h304, 32'h55, 32'h8000_0000, cyc + 1);
    bus.pipe_clear = 1'b1;
    drain("wait_clear");
    clear_mip();

    // mret alone
    bus.mepc_in = 32'h0000_1234;
    bus.mret = 1'b1;
    push(1'b1, 32'h0, 32'h0, 32'h0, 32'h0000_1234, cyc + 1);
    tick();
    bus.mret = 1'b0;
    drain("mret");
    tick();

    // mret with an exception: trap only
    bus.mret = 1'b1;
    bus.exc_req = 16'h0001;
    bus.exc_tval = 32'h0000_0077;
    bus.epc = 32'h0000_0400;
    push(1'b0, 32'h0000_0000, 32'h400, 32'h77, 32'h8000_0000, cyc + 2);
    tick();
    bus.mret = 1'b0;
    bus.exc_req = '0;
    drain("mret_exc");
    repeat (3) tick();
    chk("mret_drop_busy", 32'(bus.busy), 32'd0);

    // Clear beats a simultaneous request
    bus.int_req = 16'h0004;
    bus.int_clear = 16'h0004;
    tick();
    bus.int_req = '0;
    bus.int_clear = '0;
    chk("clr_wins_mip", 32'(bus.mip), 32'd0);
    repeat (3) tick();
    chk("clr_wins_busy", 32'(bus.busy), 32'd0);

    // Global enable off: pending but no trap
    bus.mstatus_mie = 1'b0;
    bus.int_req = 16'h0200;
    tick();
    bus.int_req = '0;
    chk("gmie_mip", 32'(bus.mip), 32'h0200);
    repeat (4) tick();
    chk("gmie_busy", 32'(bus.busy), 32'd0);
    clear_mip();
    bus.mstatus_mie = 1'b1;

    // Vector target wraps modulo 2^32
    bus.mtvec = 32'hFFFF_FFF1;
    bus.epc = 32'h0000_0500;
    bus.int_req = 16'h8000;
    push(1'b0, 32'h8000_000F, 32'h500, 32'h0, 32'h0000_002C, cyc + 3);
    tick();
    bus.int_req = '0;
    drain("vec_wrap");
    clear_mip();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
